// File: rtl/sel_seq_pkg.sv
// Shared types and helpers for the sel_seq weight sequencer: sweep state
// encoding and the beat-index width calculation.
package sel_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_BWD  = 2'd2
    } sel_state_t;

    // Beat index width; never narrower than one bit so BEATS=1 still builds.
    function automatic int calc_idx_w(input int beats);
        if (beats <= 1) begin
            return 1;
        end
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/sel_seq_mux.sv
// Combinational lane extractor: selects beat idx from the snapshot, with lane
// j carrying weight idx*LANES+j.
module sel_seq_mux #(
    parameter int WEIGHT_N   = 8,
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 1,
    parameter int IDX_W      = 3
) (
    input  logic [WEIGHT_N*DATA_WIDTH-1:0] snapshot,
    input  logic [IDX_W-1:0]               idx,
    output logic [LANES*DATA_WIDTH-1:0]    data
);

    always_comb begin
        int base;
        data = '0;
        base = int'(idx) * LANES;
        for (int j = 0; j < LANES; j++) begin
            data[j*DATA_WIDTH +: DATA_WIDTH] = snapshot[(base + j)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/sel_seq_block.sv
// Weight sweep sequencer: snapshots a weight bank on a token and streams it
// LANES weights per beat, forward or backward. Optional SEL_SEQ_SWEEP_CNT_EN
// adds a 16-bit sweep start counter output.
module sel_seq_block
    import sel_seq_pkg::*;
#(
    parameter int WEIGHT_N   = 8,
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WEIGHT_N*DATA_WIDTH-1:0] data_in,
    input  logic                           go_in_l,
    input  logic                           go_in_r,
    input  logic                           stall,
    output logic [LANES*DATA_WIDTH-1:0]    data_out,
    output logic                           valid_out,
    output logic                           go_out_r,
    output logic                           go_out_l,
    output logic                           freeze_r,
    output logic                           overrun,
`ifdef SEL_SEQ_SWEEP_CNT_EN
    output logic [15:0]                    sweep_cnt,
`endif
    output sel_state_t                     dbg_state
);

    localparam int BEATS = WEIGHT_N / LANES;
    localparam int IDX_W = calc_idx_w(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    // Handshake: go_in_l/go_in_r are single-cycle requests sampled on every
    // rising edge; go_out_r/go_out_l are single-cycle tokens issued only at a
    // sweep start; valid_out marks a live beat and stall holds it in place.

    sel_state_t                     state, state_n;
    logic [IDX_W-1:0]               idx, idx_n;
    logic                           pend_l, pend_l_n;
    logic                           pend_r, pend_r_n;
    logic [WEIGHT_N*DATA_WIDTH-1:0] snapshot;
    logic                           start_fwd, start_bwd;
    logic                           ovr_set;
    logic [LANES*DATA_WIDTH-1:0]    beat_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            pend_l   <= 1'b0;
            pend_r   <= 1'b0;
            snapshot <= '0;
            go_out_r <= 1'b0;
            go_out_l <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            pend_l   <= pend_l_n;
            pend_r   <= pend_r_n;
            go_out_r <= start_fwd;
            go_out_l <= start_bwd;
            if (start_fwd || start_bwd) begin
                snapshot <= data_in;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        logic final_beat;
        logic decide;
        logic pl_eff;
        logic pr_eff;
        state_n   = state;
        idx_n     = idx;
        pend_l_n  = pend_l;
        pend_r_n  = pend_r;
        start_fwd = 1'b0;
        start_bwd = 1'b0;
        // A request arriving on the final cycle joins its queue bit and is
        // eligible immediately, so back-to-back sweeps never bubble.
        pl_eff    = pend_l | go_in_l;
        pr_eff    = pend_r | go_in_r;
        ovr_set   = (go_in_l & pend_l) | (go_in_r & pend_r);
        final_beat = ((state == ST_FWD) && (idx == LAST_IDX)) ||
                     ((state == ST_BWD) && (idx == '0));
        decide     = (state == ST_IDLE) || (final_beat && !stall);

        if (decide) begin
            if (pl_eff) begin
                start_fwd = 1'b1;
                state_n   = ST_FWD;
                idx_n     = '0;
                pend_l_n  = 1'b0;
                pend_r_n  = pr_eff;
            end else if (pr_eff) begin
                start_bwd = 1'b1;
                state_n   = ST_BWD;
                idx_n     = LAST_IDX;
                pend_l_n  = 1'b0;
                pend_r_n  = 1'b0;
            end else begin
                state_n   = ST_IDLE;
                pend_l_n  = 1'b0;
                pend_r_n  = 1'b0;
            end
        end else begin
            pend_l_n = pl_eff;
            pend_r_n = pr_eff;
            if (!stall) begin
                if (state == ST_FWD) begin
                    idx_n = idx + IDX_W'(1);
                end else if (state == ST_BWD) begin
                    idx_n = idx - IDX_W'(1);
                end
            end
        end
    end

`ifdef SEL_SEQ_SWEEP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (start_fwd || start_bwd) begin
            sweep_cnt <= sweep_cnt + 16'd1;
        end
    end
`endif

    sel_seq_mux #(
        .WEIGHT_N  (WEIGHT_N),
        .DATA_WIDTH(DATA_WIDTH),
        .LANES     (LANES),
        .IDX_W     (IDX_W)
    ) u_mux (
        .snapshot(snapshot),
        .idx     (idx),
        .data    (beat_data)
    );

    assign valid_out = (state != ST_IDLE);
    assign data_out  = valid_out ? beat_data : '0;
    assign freeze_r  = pend_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_sel_seq_block.sv
// Self-checking bench for sel_seq_block: a LANES=1 and a LANES=2 instance run
// side by side against a sweep-sequence reference model.
module tb_sel_seq_block;
    import sel_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic        go_in_l = 1'b0;
    logic        go_in_r = 1'b0;
    logic        stall = 1'b0;

    logic [3:0]  data_out1;
    logic [7:0]  data_out2;
    logic        valid1, valid2, gor1, gor2, gol1, gol2, frz1, frz2, ovr1, ovr2;
    sel_state_t  st1, st2;
`ifdef SEL_SEQ_SWEEP_CNT_EN
    logic [15:0] cnt1, cnt2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sel_seq_block #(.WEIGHT_N(8), .DATA_WIDTH(4), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .go_in_l(go_in_l), .go_in_r(go_in_r),
        .stall(stall), .data_out(data_out1), .valid_out(valid1), .go_out_r(gor1),
        .go_out_l(gol1), .freeze_r(frz1), .overrun(ovr1),
`ifdef SEL_SEQ_SWEEP_CNT_EN
        .sweep_cnt(cnt1),
`endif
        .dbg_state(st1)
    );

    sel_seq_block #(.WEIGHT_N(8), .DATA_WIDTH(4), .LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .go_in_l(go_in_l), .go_in_r(go_in_r),
        .stall(stall), .data_out(data_out2), .valid_out(valid2), .go_out_r(gor2),
        .go_out_l(gol2), .freeze_r(frz2), .overrun(ovr2),
`ifdef SEL_SEQ_SWEEP_CNT_EN
        .sweep_cnt(cnt2),
`endif
        .dbg_state(st2)
    );

    // Reference model: each sweep is a precomputed list of beat words that is
    // replayed one entry per non-stalled cycle.
    logic [7:0]  m_seq [2][8];
    int          m_len [2];
    int          m_pos [2];
    logic        m_busy[2];
    logic        m_pl  [2];
    logic        m_pr  [2];
    logic        m_ovr [2];
    logic        m_gor [2];
    logic        m_gol [2];
    logic [15:0] m_cnt [2];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_len[k] = 0; m_pos[k] = 0; m_busy[k] = 1'b0;
            m_pl[k] = 1'b0; m_pr[k] = 1'b0; m_ovr[k] = 1'b0;
            m_gor[k] = 1'b0; m_gol[k] = 1'b0; m_cnt[k] = 16'd0;
        end
    endtask

    task automatic model_start(input int k, input int lanes, input logic fwd);
        int beats;
        logic [31:0] d;
        logic [7:0] mask;
        beats = 8 / lanes;
        mask  = (lanes == 1) ? 8'h0F : 8'hFF;
        d     = data_in;
        for (int b = 0; b < beats; b++) begin
            int w;
            w = fwd ? b : (beats - 1 - b);
            m_seq[k][b] = 8'(d >> (w * lanes * 4)) & mask;
        end
        m_len[k]  = beats;
        m_pos[k]  = 0;
        m_busy[k] = 1'b1;
        m_gor[k]  = fwd;
        m_gol[k]  = !fwd;
        m_cnt[k]  = m_cnt[k] + 16'd1;
    endtask

    task automatic model_step(input int k, input int lanes);
        logic at_end;
        m_gor[k] = 1'b0;
        m_gol[k] = 1'b0;
        if ((go_in_l && m_pl[k]) || (go_in_r && m_pr[k])) m_ovr[k] = 1'b1;
        at_end = !m_busy[k] || (!stall && m_pos[k] == m_len[k] - 1);
        if (at_end) begin
            if (m_pl[k] || go_in_l) begin
                m_pr[k] = m_pr[k] || go_in_r;
                m_pl[k] = 1'b0;
                model_start(k, lanes, 1'b1);
            end else if (m_pr[k] || go_in_r) begin
                m_pr[k] = 1'b0;
                model_start(k, lanes, 1'b0);
            end else begin
                m_busy[k] = 1'b0;
            end
        end else begin
            m_pl[k] = m_pl[k] || go_in_l;
            m_pr[k] = m_pr[k] || go_in_r;
            if (!stall) m_pos[k]++;
        end
    endtask

    function automatic logic [7:0] exp_data(input int k);
        return m_busy[k] ? m_seq[k][m_pos[k]] : 8'h00;
    endfunction

    task automatic check_all();
        chk("valid1", 16'(valid1), 16'(m_busy[0]));
        chk("data1",  16'(data_out1), 16'(exp_data(0)));
        chk("gor1",   16'(gor1), 16'(m_gor[0]));
        chk("gol1",   16'(gol1), 16'(m_gol[0]));
        chk("frz1",   16'(frz1), 16'(m_pr[0]));
        chk("ovr1",   16'(ovr1), 16'(m_ovr[0]));
        chk("valid2", 16'(valid2), 16'(m_busy[1]));
        chk("data2",  16'(data_out2), 16'(exp_data(1)));
        chk("gor2",   16'(gor2), 16'(m_gor[1]));
        chk("gol2",   16'(gol2), 16'(m_gol[1]));
        chk("frz2",   16'(frz2), 16'(m_pr[1]));
        chk("ovr2",   16'(ovr2), 16'(m_ovr[1]));
`ifdef SEL_SEQ_SWEEP_CNT_EN
        chk("cnt1", cnt1, m_cnt[0]);
        chk("cnt2", cnt2, m_cnt[1]);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out"}, {4'h0, data_out2, data_out1}, 16'h0);
        chk({tag, "_flags"}, 16'({valid1, gor1, gol1, frz1, ovr1, valid2, gor2, gol2, frz2, ovr2}), 16'h0);
    endtask

    task automatic cyc(input logic gl, input logic gr, input logic st);
        go_in_l = gl;
        go_in_r = gr;
        stall   = st;
        @(posedge clk);
        model_step(0, 1);
        model_step(1, 2);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        data_in = 32'hECA86420;
        // Forward, then backward sweep on the reference pattern.
        cyc(1'b1, 1'b0, 1'b0);
        chk("fwd_first1", 16'(data_out1), 16'h0);
        chk("fwd_first2", 16'(data_out2), 16'h20);
        idle(10);
        cyc(1'b0, 1'b1, 1'b0);
        chk("bwd_first1", 16'(data_out1), 16'hE);
        chk("bwd_first2", 16'(data_out2), 16'hEC);
        idle(10);

        // Simultaneous requests: forward then backward, no bubble.
        cyc(1'b1, 1'b1, 1'b0);
        idle(20);

        // Stall on beat index 2.
        cyc(1'b1, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        idle(8);

        // Two backward requests in one forward sweep.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(20);
        chk("ovr_sticky1", 16'(ovr1), 16'h1);
        chk("ovr_sticky2", 16'(ovr2), 16'h1);

        // Asynchronous reset in the middle of a sweep.
        data_in = 32'h13579BDF;
        cyc(1'b1, 1'b0, 1'b0);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        chk("rst_idle1", 16'(st1), 16'(ST_IDLE));
        cyc(1'b1, 1'b0, 1'b0);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) data_in = $urandom;
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 4) == 0));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
